mem_arbiter: RTL and testbench

//  Shares the single-port 64 KB mem_RAM between the instruction-fetch port (I, read-only)
//  and the load/store port (D, read/write with byte mask). Accepts one request at a time

---
 rtl/mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between an instruction-fetch port (I, read-only)
// and a load/store port (D, read/write with byte mask). One transaction in flight.
// The three-step sequence is IDLE -> ISSUE -> RESP, which gives:
//   req_ready in cycle N, mem_en in N+1, rsp_valid in N+2.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : round-robin arbitration between I and D on simultaneous requests
//   undefined : fixed priority, D wins ties
//
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   i_req_valid/ready/addr        I-port request handshake (ready is a 1-cycle pulse)
//   i_rsp_valid/rdata             I-port read response (valid is a 1-cycle pulse)
//   d_req_valid/ready/addr/wdata  D-port request handshake
//   d_req_wr_mask                 D-port byte enables, 4'b0000 means read
//   d_rsp_valid/rdata             D-port completion (rdata is 0 for writes)
//   mem_en/addr/wdata/wr_mask     RAM chip select, byte address, write data, byte mask
//   mem_rdata                     RAM read data, valid the cycle after the read edge
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [3:0]            d_req_wr_mask,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wr_mask,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e r_state, w_state_d;

  // Owner of the in-flight transaction: 1 = D port, 0 = I port.
  logic                  r_owner_d, w_owner_d;
  logic [ADDR_WIDTH-1:0] r_lat_addr, w_lat_addr;
  logic [DATA_WIDTH-1:0] r_lat_wdata, w_lat_wdata;
  logic [3:0]            r_lat_mask, w_lat_mask;

  logic                  r_i_req_ready, w_i_req_ready;
  logic                  r_d_req_ready, w_d_req_ready;
  logic                  r_i_rsp_valid, w_i_rsp_valid;
  logic                  r_d_rsp_valid, w_d_rsp_valid;
  logic                  r_d_rsp_rd, w_d_rsp_rd;
  logic                  r_mem_en, w_mem_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic [3:0]            r_mem_wr_mask, w_mem_wr_mask;

  // Response data is last returned value while rsp_valid is low.
  logic [DATA_WIDTH-1:0] r_i_rdata_hold;
  logic [DATA_WIDTH-1:0] r_d_rdata_hold;
  logic [DATA_WIDTH-1:0] w_d_rdata;

  logic w_grant_i;
  logic w_grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Preferred port on a tie: 0 = I, 1 = D. After each grant it points at the loser.
  logic r_rr_ptr;

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (i_req_valid && d_req_valid) begin
      if (r_rr_ptr) begin
        w_grant_d = 1'b1;
      end else begin
        w_grant_i = 1'b1;
      end
    end else begin
      w_grant_i = i_req_valid;
      w_grant_d = d_req_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if (r_state == StIdle && (w_grant_i || w_grant_d)) begin
      r_rr_ptr <= w_grant_i;
    end
  end
`else
  always_comb begin
    w_grant_d = d_req_valid;
    w_grant_i = i_req_valid && !d_req_valid;
  end
`endif

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner_d;
    w_lat_addr    = r_lat_addr;
    w_lat_wdata   = r_lat_wdata;
    w_lat_mask    = r_lat_mask;
    w_i_req_ready = 1'b0;
    w_d_req_ready = 1'b0;
    w_i_rsp_valid = 1'b0;
    w_d_rsp_valid = 1'b0;
    w_d_rsp_rd    = r_d_rsp_rd;
    w_mem_en      = 1'b0;
    w_mem_addr    = r_mem_addr;
    w_mem_wdata   = r_mem_wdata;
    w_mem_wr_mask = 4'b0000;

    case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          w_d_req_ready = 1'b1;
          w_owner_d     = 1'b1;
          w_lat_addr    = d_req_addr;
          w_lat_wdata   = d_req_wdata;
          w_lat_mask    = d_req_wr_mask;
          w_state_d     = StIssue;
        end else if (w_grant_i) begin
          w_i_req_ready = 1'b1;
          w_owner_d     = 1'b0;
          w_lat_addr    = i_req_addr;
          w_lat_wdata   = '0;
          w_lat_mask    = 4'b0000;
          w_state_d     = StIssue;
        end
      end
      StIssue: begin
        w_mem_en      = 1'b1;
        w_mem_addr    = r_lat_addr;
        w_mem_wdata   = r_lat_wdata;
        w_mem_wr_mask = r_owner_d ? r_lat_mask : 4'b0000;
        w_state_d     = StResp;
      end
      StResp: begin
        if (r_owner_d) begin
          w_d_rsp_valid = 1'b1;
          w_d_rsp_rd    = (r_lat_mask == 4'b0000);
        end else begin
          w_i_rsp_valid = 1'b1;
        end
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StIdle;
      r_owner_d      <= 1'b0;
      r_lat_addr     <= '0;
      r_lat_wdata    <= '0;
      r_lat_mask     <= 4'b0000;
      r_i_req_ready  <= 1'b0;
      r_d_req_ready  <= 1'b0;
      r_i_rsp_valid  <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_rd     <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_wr_mask  <= 4'b0000;
      r_i_rdata_hold <= '0;
      r_d_rdata_hold <= '0;
    end else begin
      r_state        <= w_state_d;
      r_owner_d      <= w_owner_d;
      r_lat_addr     <= w_lat_addr;
      r_lat_wdata    <= w_lat_wdata;
      r_lat_mask     <= w_lat_mask;
      r_i_req_ready  <= w_i_req_ready;
      r_d_req_ready  <= w_d_req_ready;
      r_i_rsp_valid  <= w_i_rsp_valid;
      r_d_rsp_valid  <= w_d_rsp_valid;
      r_d_rsp_rd     <= w_d_rsp_rd;
      r_mem_en       <= w_mem_en;
      r_mem_addr     <= w_mem_addr;
      r_mem_wdata    <= w_mem_wdata;
      r_mem_wr_mask  <= w_mem_wr_mask;
      if (r_i_rsp_valid) begin
        r_i_rdata_hold <= mem_rdata;
      end
      if (r_d_rsp_valid) begin
        r_d_rdata_hold <= w_d_rdata;
      end
    end
  end

  // The RAM presents read data only in the response cycle itself, so the data path is a
  // registered-select mux onto mem_rdata rather than a second register stage.
  always_comb begin
    w_d_rdata = r_d_rsp_rd ? mem_rdata : '0;
  end

  assign i_req_ready = r_i_req_ready;
  assign d_req_ready = r_d_req_ready;
  assign i_rsp_valid = r_i_rsp_valid;
  assign d_rsp_valid = r_d_rsp_valid;
  assign i_rsp_rdata = r_i_rsp_valid ? mem_rdata : r_i_rdata_hold;
  assign d_rsp_rdata = r_d_rsp_valid ? w_d_rdata : r_d_rdata_hold;
  assign mem_en      = r_mem_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wr_mask = r_mem_wr_mask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64 KB single-port RAM.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_rdata;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wr_mask;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:16383];

  int n_checks;
  int n_errors;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_rsp_valid  (i_rsp_valid),
    .i_rsp_rdata  (i_rsp_rdata),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_wdata  (d_req_wdata),
    .d_req_wr_mask(d_req_wr_mask),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_rdata  (d_rsp_rdata),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr_mask  (mem_wr_mask),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-masked write, read data registered on the enabled edge.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_mask[b]) ram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr[15:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one granted transaction from IDLE: ready, issue and response cycles.
  task automatic run_txn(input string tag, input logic exp_d, input logic [31:0] exp_addr,
                         input logic [3:0] exp_mask, input logic [31:0] exp_rdata,
                         input logic drop_i, input logic drop_d);
    tick();
    chk({tag, "_i_ready"}, {31'd0, i_req_ready}, {31'd0, !exp_d});
    chk({tag, "_d_ready"}, {31'd0, d_req_ready}, {31'd0, exp_d});
    if (drop_i) i_req_valid = 1'b0;
    if (drop_d) d_req_valid = 1'b0;
    tick();
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_mem_mask"}, {28'd0, mem_wr_mask}, {28'd0, exp_mask});
    tick();
    chk({tag, "_mem_en_off"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_i_rsp_valid"}, {31'd0, i_rsp_valid}, {31'd0, !exp_d});
    chk({tag, "_d_rsp_valid"}, {31'd0, d_rsp_valid}, {31'd0, exp_d});
    if (exp_d) chk({tag, "_d_rdata"}, d_rsp_rdata, exp_rdata);
    else       chk({tag, "_i_rdata"}, i_rsp_rdata, exp_rdata);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int w = 0; w < 16384; w++) ram[w] = 32'd0;
    ram[4]        = 32'hDEADBEEF;
    mem_rdata     = 32'd0;
    reset         = 1'b1;
    i_req_valid   = 1'b0;
    i_req_addr    = 32'd0;
    d_req_valid   = 1'b0;
    d_req_addr    = 32'd0;
    d_req_wdata   = 32'd0;
    d_req_wr_mask = 4'b0000;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_i_ready", {31'd0, i_req_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rdata", i_rsp_rdata, 32'd0);
    chk("rst_d_rdata", d_rsp_rdata, 32'd0);

    // 1: I read of word 4
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0010;
    run_txn("t1", 1'b0, 32'h10, 4'b0000, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    chk("t1_hold_valid", {31'd0, i_rsp_valid}, 32'd0);
    chk("t1_hold_rdata", i_rsp_rdata, 32'hDEADBEEF);
    chk("t1_hold_addr", mem_addr, 32'h10);

    // 2: masked D write, then D read back
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h20;
    d_req_wdata   = 32'h1122_3344;
    d_req_wr_mask = 4'b0101;
    run_txn("t2_wr", 1'b1, 32'h20, 4'b0101, 32'd0, 1'b0, 1'b1);
    chk("t2_wdata", mem_wdata, 32'h1122_3344);
    d_req_valid   = 1'b1;
    d_req_wr_mask = 4'b0000;
    run_txn("t2_rd", 1'b1, 32'h20, 4'b0000, 32'h0022_0044, 1'b0, 1'b1);

    // 3: simultaneous I and D requests, both held
    i_req_valid = 1'b1;
    i_req_addr  = 32'h10;
    d_req_valid = 1'b1;
    d_req_addr  = 32'h20;
`ifdef ARB_ROUND_ROBIN_EN
    run_txn("t3_g1", 1'b0, 32'h10, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
    run_txn("t3_g2", 1'b1, 32'h20, 4'b0000, 32'h0022_0044, 1'b0, 1'b1);
    run_txn("t3_g3", 1'b0, 32'h10, 4'b0000, 32'hDEADBEEF, 1'b1, 1'b0);
`else
    run_txn("t3_g1", 1'b1, 32'h20, 4'b0000, 32'h0022_0044, 1'b0, 1'b0);
    run_txn("t3_g2", 1'b1, 32'h20, 4'b0000, 32'h0022_0044, 1'b0, 1'b1);
    run_txn("t3_g3", 1'b0, 32'h10, 4'b0000, 32'hDEADBEEF, 1'b1, 1'b0);
`endif

    // 4: D valid held for four back-to-back transactions
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h14;
    d_req_wdata   = 32'hA5A5_A5A5;
    d_req_wr_mask = 4'b1111;
    run_txn("t4_wr", 1'b1, 32'h14, 4'b1111, 32'd0, 1'b0, 1'b0);
    d_req_wr_mask = 4'b0000;
    run_txn("t4_rd14", 1'b1, 32'h14, 4'b0000, 32'hA5A5_A5A5, 1'b0, 1'b0);
    d_req_addr = 32'h10;
    run_txn("t4_rd10", 1'b1, 32'h10, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b0);
    d_req_addr = 32'h20;
    run_txn("t4_rd20", 1'b1, 32'h20, 4'b0000, 32'h0022_0044, 1'b0, 1'b1);
    tick();

    // 5: reset pulse during ISSUE of a D write
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h30;
    d_req_wdata   = 32'h5555_5555;
    d_req_wr_mask = 4'b1111;
    tick();
    chk("t5_d_ready", {31'd0, d_req_ready}, 32'd1);
    d_req_valid = 1'b0;
    tick();
    chk("t5_issue_en", {31'd0, mem_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_en", {31'd0, mem_en}, 32'd0);
    #1 reset = 1'b0;
    tick();
    chk("t5_no_rsp", {31'd0, d_rsp_valid}, 32'd0);
    chk("t5_idle_en", {31'd0, mem_en}, 32'd0);
    tick();
    chk("t5_no_rsp2", {31'd0, d_rsp_valid}, 32'd0);

    // 6: unaligned I address passes through untouched
    i_req_valid = 1'b1;
    i_req_addr  = 32'h3;
    run_txn("t6", 1'b0, 32'h3, 4'b0000, 32'd0, 1'b1, 1'b0);

    // Aborted write must not have reached the RAM
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h30;
    d_req_wr_mask = 4'b0000;
    run_txn("t5_rd30", 1'b1, 32'h30, 4'b0000, 32'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
